// File: rtl/part_dpram_param_pkg.sv
// Shared constants and state encoding for the parametrised dual-port RAM.
package part_dpram_param_pkg;

    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/part_dpram_core.sv
// Storage array with two synchronous read-first ports and per-byte write enables.
// Callers guarantee in-range addresses and non-overlapping byte enables on same-address writes.
module part_dpram_core #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 21504,
    parameter int AWIDTH = 15
) (
    input  logic                 clk,
    input  logic [AWIDTH-1:0]    a_addr_i,
    input  logic [WIDTH-1:0]     a_data_i,
    input  logic [WIDTH/8-1:0]   a_be_i,
    input  logic                 a_we_i,
    input  logic                 a_re_i,
    output logic [WIDTH-1:0]     a_rdata_o,
    input  logic [AWIDTH-1:0]    b_addr_i,
    input  logic [WIDTH-1:0]     b_data_i,
    input  logic [WIDTH/8-1:0]   b_be_i,
    input  logic                 b_we_i,
    input  logic                 b_re_i,
    output logic [WIDTH-1:0]     b_rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    // array write by byte lanes; reads return the word as it was before this edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (a_we_i && a_be_i[i]) begin
                mem_q[a_addr_i][8*i +: 8] <= a_data_i[8*i +: 8];
            end
            if (b_we_i && b_be_i[i]) begin
                mem_q[b_addr_i][8*i +: 8] <= b_data_i[8*i +: 8];
            end
        end
        if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
        if (b_re_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/part_dpram_param.sv
// True dual-port RAM wrapper: post-reset clear sweep, range checking, collision merge,
// read-during-write bypass and optional output register around part_dpram_core.
module part_dpram_param
    import part_dpram_param_pkg::*;
#(
    parameter int              WIDTH          = 32,
    parameter int              DEPTH          = 21504,
    parameter int              AWIDTH         = 15,
    parameter int              RDW_MODE       = 0,
    parameter int              OUT_REG        = 0,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic [AWIDTH-1:0]    a_addr,
    input  logic [WIDTH-1:0]     a_data,
    input  logic [WIDTH/8-1:0]   a_be,
    input  logic                 a_wren,
    input  logic                 a_rden,
    output logic [WIDTH-1:0]     a_q,
    output logic                 a_valid,
    input  logic [AWIDTH-1:0]    b_addr,
    input  logic [WIDTH-1:0]     b_data,
    input  logic [WIDTH/8-1:0]   b_be,
    input  logic                 b_wren,
    input  logic                 b_rden,
    output logic [WIDTH-1:0]     b_q,
    output logic                 b_valid,
    output logic                 collision,
    output logic [1:0]           addr_err
);

    localparam int               NB        = WIDTH / 8;
    localparam int               CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0]  DEPTH_W   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam bit               RDW_NEW   = (RDW_MODE == RDW_NEW_DATA);

    function automatic logic [WIDTH-1:0] be_to_mask(input logic [NB-1:0] be);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_e            st_q, st_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              clear_s;

    logic              a_inr_s, b_inr_s, a_rd_s, b_rd_s, a_wr_s, b_wr_s, same_s;
    logic [NB-1:0]     b_be_eff_s, a_ovm_s, b_ovm_s, a_self_s, a_for_b_s;
    logic [WIDTH-1:0]  a_ovd_s, b_ovd_s;
    logic              col_s;
    logic [1:0]        err_s;

    logic [CW-1:0]     core_a_addr_s;
    logic [WIDTH-1:0]  core_a_data_s, a_core_q, b_core_q;
    logic [NB-1:0]     core_a_be_s;
    logic              core_a_we_s;

    logic              a_zero_q, b_zero_q, a_v1_q, b_v1_q, a_v2_q, b_v2_q, col_q;
    logic [NB-1:0]     a_ovm_q, b_ovm_q;
    logic [WIDTH-1:0]  a_ovd_q, b_ovd_q, a_q2_q, b_q2_q, a_res_s, b_res_s;
    logic [1:0]        err_q;

    // state register and clear counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= ST_RESET;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // next-state logic
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_RESET: st_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    st_d = ST_RUN;
                end else begin
                    st_d = ST_CLEAR;
                end
            end
            ST_RUN:   st_d = ST_RUN;
            default:  st_d = ST_RESET;
        endcase
    end

    // FSM outputs: sweep enable, counter advance, ready
    always_comb begin
        clear_s = 1'b0;
        cnt_d   = '0;
        case (st_q)
            ST_CLEAR: begin
                clear_s = 1'b1;
                cnt_d   = cnt_q + AWIDTH'(1'b1);
            end
            ST_RESET, ST_RUN: begin
                clear_s = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                clear_s = 1'b0;
                cnt_d   = '0;
            end
        endcase
        ready_d = (st_d == ST_RUN);
    end

    // request decode, collision merge and bypass overlays
    always_comb begin
        a_inr_s = ({1'b0, a_addr} < DEPTH_W);
        b_inr_s = ({1'b0, b_addr} < DEPTH_W);
        a_rd_s  = ready_q & a_rden;
        b_rd_s  = ready_q & b_rden;
        a_wr_s  = ready_q & a_wren & a_inr_s;
        b_wr_s  = ready_q & b_wren & b_inr_s;
        same_s  = (a_addr == b_addr);
        // port A owns any byte both ports write
        if (a_wr_s && same_s) begin
            b_be_eff_s = b_be & ~a_be;
            a_for_b_s  = a_be;
        end else begin
            b_be_eff_s = b_be;
            a_for_b_s  = '0;
        end
        a_self_s = a_wr_s ? a_be : '0;
        a_ovm_s  = a_self_s | ((RDW_NEW && b_wr_s && same_s) ? b_be_eff_s : '0);
        a_ovd_s  = (a_data & be_to_mask(a_self_s)) | (b_data & ~be_to_mask(a_self_s));
        b_ovm_s  = (b_wr_s ? b_be_eff_s : '0) | (RDW_NEW ? a_for_b_s : '0);
        b_ovd_s  = (a_data & be_to_mask(a_for_b_s)) | (b_data & ~be_to_mask(a_for_b_s));
        col_s    = a_wr_s & b_wr_s & same_s & (|(a_be & b_be));
        err_s    = {ready_q & (b_rden | b_wren) & ~b_inr_s,
                    ready_q & (a_rden | a_wren) & ~a_inr_s};
        core_a_addr_s = clear_s ? cnt_q[CW-1:0] : a_addr[CW-1:0];
        core_a_data_s = clear_s ? CLEAR_VALUE : a_data;
        core_a_be_s   = clear_s ? {NB{1'b1}} : a_be;
        core_a_we_s   = clear_s | a_wr_s;
    end

    part_dpram_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (CW)
    ) u_core (
        .clk       (clk),
        .a_addr_i  (core_a_addr_s),
        .a_data_i  (core_a_data_s),
        .a_be_i    (core_a_be_s),
        .a_we_i    (core_a_we_s),
        .a_re_i    (a_rd_s & a_inr_s),
        .a_rdata_o (a_core_q),
        .b_addr_i  (b_addr[CW-1:0]),
        .b_data_i  (b_data),
        .b_be_i    (b_be_eff_s),
        .b_we_i    (b_wr_s),
        .b_re_i    (b_rd_s & b_inr_s),
        .b_rdata_o (b_core_q)
    );

    // capture per-read overlay; zero flag forces 0 for out-of-range reads and after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_zero_q <= 1'b1;
            b_zero_q <= 1'b1;
            a_ovm_q  <= '0;
            b_ovm_q  <= '0;
            a_ovd_q  <= '0;
            b_ovd_q  <= '0;
            a_v1_q   <= 1'b0;
            b_v1_q   <= 1'b0;
            col_q    <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            if (a_rd_s) begin
                a_zero_q <= ~a_inr_s;
                a_ovm_q  <= a_ovm_s;
                a_ovd_q  <= a_ovd_s;
            end
            if (b_rd_s) begin
                b_zero_q <= ~b_inr_s;
                b_ovm_q  <= b_ovm_s;
                b_ovd_q  <= b_ovd_s;
            end
            a_v1_q <= a_rd_s;
            b_v1_q <= b_rd_s;
            col_q  <= col_s;
            err_q  <= err_s;
        end
    end

    // merge raw array word with the captured overlay
    always_comb begin
        if (a_zero_q) begin
            a_res_s = '0;
        end else begin
            a_res_s = (a_core_q & ~be_to_mask(a_ovm_q)) | (a_ovd_q & be_to_mask(a_ovm_q));
        end
        if (b_zero_q) begin
            b_res_s = '0;
        end else begin
            b_res_s = (b_core_q & ~be_to_mask(b_ovm_q)) | (b_ovd_q & be_to_mask(b_ovm_q));
        end
    end

    // optional second output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q2_q <= '0;
            b_q2_q <= '0;
            a_v2_q <= 1'b0;
            b_v2_q <= 1'b0;
        end else begin
            if (a_v1_q) begin
                a_q2_q <= a_res_s;
            end
            if (b_v1_q) begin
                b_q2_q <= b_res_s;
            end
            a_v2_q <= a_v1_q;
            b_v2_q <= b_v1_q;
        end
    end

    assign a_q       = (OUT_REG != 0) ? a_q2_q : a_res_s;
    assign b_q       = (OUT_REG != 0) ? b_q2_q : b_res_s;
    assign a_valid   = (OUT_REG != 0) ? a_v2_q : a_v1_q;
    assign b_valid   = (OUT_REG != 0) ? b_v2_q : b_v1_q;
    assign ready     = ready_q;
    assign collision = col_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_part_dpram_param.sv
// Scoreboard bench for part_dpram_param: three configurations share one clock.
module tb_part_dpram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1;
    logic [4:0]  a_addr0, b_addr0, a_addr1, b_addr1;
    logic [14:0] a_addr2, b_addr2;
    logic [2:0][31:0] a_data, b_data, a_q, b_q;
    logic [2:0][3:0]  a_be, b_be;
    logic [2:0] a_wren, a_rden, b_wren, b_rden, a_valid, b_valid, ready, collision;
    logic [2:0][1:0] addr_err;

    int nvec = 0;
    int nmis = 0;
    int r0, r1, r2;

    part_dpram_param #(.WIDTH(32), .DEPTH(16), .AWIDTH(5), .RDW_MODE(0), .OUT_REG(0),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hDEADBEEF)) u0 (
        .clk(clk), .reset(rst), .ready(ready[0]),
        .a_addr(a_addr0), .a_data(a_data[0]), .a_be(a_be[0]), .a_wren(a_wren[0]),
        .a_rden(a_rden[0]), .a_q(a_q[0]), .a_valid(a_valid[0]),
        .b_addr(b_addr0), .b_data(b_data[0]), .b_be(b_be[0]), .b_wren(b_wren[0]),
        .b_rden(b_rden[0]), .b_q(b_q[0]), .b_valid(b_valid[0]),
        .collision(collision[0]), .addr_err(addr_err[0]));

    part_dpram_param #(.WIDTH(32), .DEPTH(16), .AWIDTH(5), .RDW_MODE(1), .OUT_REG(1),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hDEADBEEF)) u1 (
        .clk(clk), .reset(rst1), .ready(ready[1]),
        .a_addr(a_addr1), .a_data(a_data[1]), .a_be(a_be[1]), .a_wren(a_wren[1]),
        .a_rden(a_rden[1]), .a_q(a_q[1]), .a_valid(a_valid[1]),
        .b_addr(b_addr1), .b_data(b_data[1]), .b_be(b_be[1]), .b_wren(b_wren[1]),
        .b_rden(b_rden[1]), .b_q(b_q[1]), .b_valid(b_valid[1]),
        .collision(collision[1]), .addr_err(addr_err[1]));

    part_dpram_param #(.WIDTH(32), .DEPTH(21504), .AWIDTH(15), .RDW_MODE(0), .OUT_REG(0),
                       .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'h00000000)) u2 (
        .clk(clk), .reset(rst), .ready(ready[2]),
        .a_addr(a_addr2), .a_data(a_data[2]), .a_be(a_be[2]), .a_wren(a_wren[2]),
        .a_rden(a_rden[2]), .a_q(a_q[2]), .a_valid(a_valid[2]),
        .b_addr(b_addr2), .b_data(b_data[2]), .b_be(b_be[2]), .b_wren(b_wren[2]),
        .b_rden(b_rden[2]), .b_q(b_q[2]), .b_valid(b_valid[2]),
        .collision(collision[2]), .addr_err(addr_err[2]));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_wren = '0; a_rden = '0; b_wren = '0; b_rden = '0;
    endtask

    task automatic drv(int k, bit port, bit wr, bit rd, logic [14:0] addr,
                       logic [31:0] d, logic [3:0] be);
        if (port == 1'b0) begin
            a_wren[k] = wr; a_rden[k] = rd; a_data[k] = d; a_be[k] = be;
            case (k)
                0:       a_addr0 = addr[4:0];
                1:       a_addr1 = addr[4:0];
                default: a_addr2 = addr;
            endcase
        end else begin
            b_wren[k] = wr; b_rden[k] = rd; b_data[k] = d; b_be[k] = be;
            case (k)
                0:       b_addr0 = addr[4:0];
                1:       b_addr1 = addr[4:0];
                default: b_addr2 = addr;
            endcase
        end
    endtask

    task automatic push(int k, bit port, logic [31:0] v);
        if (k == 0 && port == 1'b0)      g_mon[0].qa.push_back(v);
        else if (k == 0)                 g_mon[0].qb.push_back(v);
        else if (k == 1 && port == 1'b0) g_mon[1].qa.push_back(v);
        else if (k == 1)                 g_mon[1].qb.push_back(v);
        else if (port == 1'b0)           g_mon[2].qa.push_back(v);
        else                             g_mon[2].qb.push_back(v);
    endtask

    task automatic rd(int k, bit port, logic [14:0] addr, logic [31:0] e);
        drv(k, port, 1'b0, 1'b1, addr, 32'h0, 4'h0);
        push(k, port, e);
    endtask

    task automatic wr(int k, bit port, logic [14:0] addr, logic [31:0] d, logic [3:0] be);
        drv(k, port, 1'b1, 1'b0, addr, d, be);
    endtask

    // read-result monitors: every valid pulse must match the oldest expectation
    for (genvar k = 0; k < 3; k++) begin : g_mon
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        always @(negedge clk) begin
            if (a_valid[k]) begin
                if (qa.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL u%0d.a_valid: unexpected pulse q=%h, no read pending", k, a_q[k]);
                end else begin
                    chk($sformatf("u%0d.a_q", k), a_q[k], qa.pop_front());
                end
            end
            if (b_valid[k]) begin
                if (qb.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL u%0d.b_valid: unexpected pulse q=%h, no read pending", k, b_q[k]);
                end else begin
                    chk($sformatf("u%0d.b_q", k), b_q[k], qb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        a_addr0 = '0; b_addr0 = '0; a_addr1 = '0; b_addr1 = '0; a_addr2 = '0; b_addr2 = '0;
        a_data = '0; b_data = '0; a_be = '0; b_be = '0;
        idle();
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.reset_flags", k),
                {26'd0, ready[k], a_valid[k], b_valid[k], collision[k], addr_err[k]}, 32'd0);
            chk($sformatf("u%0d.reset_a_q", k), a_q[k], 32'd0);
            chk($sformatf("u%0d.reset_b_q", k), b_q[k], 32'd0);
        end

        // release resets; u1 gets a second reset mid-sweep (counter at 8)
        rst = 1'b0; rst1 = 1'b0;
        r0 = 0; r1 = 0; r2 = 0;
        for (int c = 1; c <= 45; c++) begin
            idle();
            if (c == 5) begin
                wr(0, 1'b1, 15'd0, 32'h00000000, 4'hF);
                drv(0, 1'b0, 1'b0, 1'b1, 15'd3, 32'h0, 4'h0);
            end
            tick();
            if (ready[0] && r0 == 0) r0 = c;
            if (ready[1] && r1 == 0) r1 = c;
            if (ready[2] && r2 == 0) r2 = c;
            if (c == 9)  rst1 = 1'b1;
            if (c == 10) rst1 = 1'b0;
        end
        chk("u0.ready_clock", r0, 32'd17);
        chk("u1.ready_after_midsweep_reset", r1, 32'd27);
        chk("u2.ready_no_clear", r2, 32'd1);

        // u0: clear contents, pipelined reads
        for (int i = 0; i < 16; i++) begin
            idle(); rd(0, 1'b0, 15'(i), 32'hDEADBEEF); tick();
        end
        idle(); rd(0, 1'b1, 15'd15, 32'hDEADBEEF); tick();
        chk("u0.b_latency1", 32'(b_valid[0]), 32'd1);
        idle(); tick();
        chk("u0.b_valid_pulse", 32'(b_valid[0]), 32'd0);
        chk("u0.b_q_hold", b_q[0], 32'hDEADBEEF);

        // u0: byte writes and same-port write-through
        idle(); wr(0, 1'b0, 15'd5, 32'h11223344, 4'b0101); tick();
        idle(); rd(0, 1'b0, 15'd5, 32'hDE22BE44); tick();
        idle(); drv(0, 1'b0, 1'b1, 1'b1, 15'd6, 32'h01020304, 4'hF); push(0, 1'b0, 32'h01020304); tick();
        idle(); drv(0, 1'b0, 1'b1, 1'b1, 15'd9, 32'hCAFEF00D, 4'b0011); push(0, 1'b0, 32'hDEADF00D); tick();
        idle(); rd(0, 1'b0, 15'd9, 32'hDEADF00D); rd(0, 1'b1, 15'd6, 32'h01020304); tick();

        // u0: mixed-port read during write returns old data
        idle(); wr(0, 1'b0, 15'd3, 32'h00000001, 4'hF); tick();
        idle(); wr(0, 1'b0, 15'd3, 32'h00000002, 4'hF); rd(0, 1'b1, 15'd3, 32'h00000001); tick();
        idle(); rd(0, 1'b1, 15'd3, 32'h00000002); tick();

        // u0: collisions
        idle(); wr(0, 1'b0, 15'd7, 32'hAAAAAAAA, 4'b1100); wr(0, 1'b1, 15'd7, 32'hBBBBBBBB, 4'b0110); tick();
        chk("u0.collision_pulse", 32'(collision[0]), 32'd1);
        idle(); rd(0, 1'b0, 15'd7, 32'hAAAABBEF); tick();
        chk("u0.collision_clear", 32'(collision[0]), 32'd0);
        idle(); wr(0, 1'b0, 15'd8, 32'hAAAAAAAA, 4'b0001); wr(0, 1'b1, 15'd8, 32'hBBBBBBBB, 4'b0010); tick();
        chk("u0.no_collision_disjoint", 32'(collision[0]), 32'd0);
        idle(); wr(0, 1'b0, 15'd10, 32'h10101010, 4'hF); wr(0, 1'b1, 15'd11, 32'h20202020, 4'hF); tick();
        chk("u0.no_collision_diff_addr", 32'(collision[0]), 32'd0);
        idle(); rd(0, 1'b0, 15'd8, 32'hDEADBBAA); rd(0, 1'b1, 15'd10, 32'h10101010); tick();
        idle(); rd(0, 1'b0, 15'd11, 32'h20202020); tick();

        // u0: zero byte-enable write and out-of-range accesses
        idle(); wr(0, 1'b0, 15'd12, 32'hFFFFFFFF, 4'h0); tick();
        chk("u0.be0_no_err", 32'(addr_err[0]), 32'd0);
        idle(); rd(0, 1'b0, 15'd12, 32'hDEADBEEF); rd(0, 1'b1, 15'd20, 32'h00000000); tick();
        chk("u0.oor_read_err", 32'(addr_err[0]), 32'd2);
        idle(); wr(0, 1'b0, 15'd16, 32'h12345678, 4'hF); tick();
        chk("u0.oor_write_err", 32'(addr_err[0]), 32'd1);
        idle(); rd(0, 1'b0, 15'd0, 32'hDEADBEEF); tick();
        chk("u0.err_clear", 32'(addr_err[0]), 32'd0);

        // u1: output-register latency and new-data policy
        idle(); rd(1, 1'b0, 15'd0, 32'hDEADBEEF); tick();
        idle();
        chk("u1.lat_n1", 32'(a_valid[1]), 32'd0);
        tick();
        chk("u1.lat_n2", 32'(a_valid[1]), 32'd1);
        tick();
        chk("u1.valid_pulse", 32'(a_valid[1]), 32'd0);
        wr(1, 1'b0, 15'd3, 32'h00000001, 4'hF); tick();
        idle(); wr(1, 1'b0, 15'd3, 32'h00000002, 4'hF); rd(1, 1'b1, 15'd3, 32'h00000002); tick();
        for (int i = 0; i < 5; i++) begin
            idle(); rd(1, 1'b1, 15'(i), (i == 3) ? 32'h00000002 : 32'hDEADBEEF); tick();
        end
        idle(); wr(1, 1'b0, 15'd7, 32'hAAAAAAAA, 4'b1100); wr(1, 1'b1, 15'd7, 32'hBBBBBBBB, 4'b0110); tick();
        chk("u1.collision_pulse", 32'(collision[1]), 32'd1);
        idle(); wr(1, 1'b1, 15'd3, 32'h0000FF00, 4'b0010); rd(1, 1'b0, 15'd3, 32'h0000FF02); tick();
        chk("u1.collision_clear", 32'(collision[1]), 32'd0);
        idle(); rd(1, 1'b0, 15'd7, 32'hAAAABBEF); tick();

        // u2: full-depth range checks
        idle(); wr(2, 1'b0, 15'd21503, 32'h12345678, 4'hF); tick();
        idle(); wr(2, 1'b0, 15'd21504, 32'hFFFFFFFF, 4'hF); tick();
        chk("u2.oor_write_err", 32'(addr_err[2]), 32'd1);
        idle(); rd(2, 1'b0, 15'd21504, 32'h00000000); tick();
        chk("u2.oor_read_err", 32'(addr_err[2]), 32'd1);
        idle(); rd(2, 1'b0, 15'd21503, 32'h12345678); rd(2, 1'b1, 15'd32767, 32'h00000000); tick();
        chk("u2.oor_b_err", 32'(addr_err[2]), 32'd2);

        idle();
        repeat (6) tick();
        chk("u0.qa_left", g_mon[0].qa.size(), 32'd0);
        chk("u0.qb_left", g_mon[0].qb.size(), 32'd0);
        chk("u1.qa_left", g_mon[1].qa.size(), 32'd0);
        chk("u1.qb_left", g_mon[1].qb.size(), 32'd0);
        chk("u2.qa_left", g_mon[2].qa.size(), 32'd0);
        chk("u2.qb_left", g_mon[2].qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
